// File: rtl/ovf_accumulator_pkg.sv
// Shared arithmetic definitions for signed saturating datapath blocks.
// Holds the add/sub op encoding and signed MAX/MIN limit derivation.
package ovf_accumulator_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Limits come back as 64-bit patterns; callers cast to their own
    // WIDTH, which keeps the low WIDTH bits (two's complement pattern).
    function automatic logic [63:0] sat_max(input int unsigned w);
        return (64'(1) << (w - 1)) - 64'(1);
    endfunction

    function automatic logic [63:0] sat_min(input int unsigned w);
        return 64'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/ovf_detect_n.sv
// Combinational WIDTH-bit signed add/sub with overflow detection.
// Ports: a, b operands; sub selects a-b; result, ovf, ovf_neg (direction).
module ovf_detect_n
    import ovf_accumulator_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             ovf_neg
);

    logic [WIDTH:0] ext_a;
    logic [WIDTH:0] ext_b;
    logic [WIDTH:0] ext;

    assign ext_a = {a[WIDTH-1], a};
    assign ext_b = {b[WIDTH-1], b};

    // One guard bit is enough: the sum/difference of two WIDTH-bit
    // signed values always fits in WIDTH+1 bits, including a - MIN.
    always_comb begin
        if (sub == OP_SUB) begin
            ext = ext_a - ext_b;
        end else begin
            ext = ext_a + ext_b;
        end
    end

    assign result  = ext[WIDTH-1:0];
    assign ovf     = ext[WIDTH] ^ ext[WIDTH-1];
    assign ovf_neg = ovf & ext[WIDTH];

endmodule

// File: rtl/ovf_accumulator.sv
// Signed accumulator with wrap/saturate, overflow pulse, sticky flag
// and saturating overflow-event counter. All outputs are registered.
// Ports: CLK, RST (sync, active-high), EN, CLR, SUB, SAT, D in;
//        ACC, OVF, STICKY, OVF_CNT out.
module ovf_accumulator
    import ovf_accumulator_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 EN,
    input  logic                 CLR,
    input  logic                 SUB,
    input  logic                 SAT,
    input  logic [WIDTH-1:0]     D,
    output logic [WIDTH-1:0]     ACC,
    output logic                 OVF,
    output logic                 STICKY,
    output logic [CNT_WIDTH-1:0] OVF_CNT
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] MIN_V = WIDTH'(sat_min(WIDTH));

    logic [WIDTH-1:0]     acc_q;
    logic [WIDTH-1:0]     acc_d;
    logic                 ovf_q;
    logic                 ovf_d;
    logic                 sticky_q;
    logic                 sticky_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    logic [WIDTH-1:0]     sum;
    logic                 sum_ovf;
    logic                 sum_ovf_neg;

    ovf_detect_n #(
        .WIDTH(WIDTH)
    ) u_detect (
        .a       (acc_q),
        .b       (D),
        .sub     (SUB),
        .result  (sum),
        .ovf     (sum_ovf),
        .ovf_neg (sum_ovf_neg)
    );

    // CLR outranks EN: an operand presented with CLR is dropped.
    always_comb begin
        acc_d    = acc_q;
        ovf_d    = 1'b0;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        if (CLR) begin
            acc_d    = '0;
            sticky_d = 1'b0;
            cnt_d    = '0;
        end else if (EN) begin
            acc_d = sum;
            if (sum_ovf) begin
                ovf_d    = 1'b1;
                sticky_d = 1'b1;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
                if (SAT) begin
                    acc_d = sum_ovf_neg ? MIN_V : MAX_V;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ACC     = acc_q;
    assign OVF     = ovf_q;
    assign STICKY  = sticky_q;
    assign OVF_CNT = cnt_q;

endmodule

// File: tb/tb_ovf_accumulator.sv
// Self-checking bench for ovf_accumulator (WIDTH=8, CNT_WIDTH=4).
// Directed cases followed by random operations against an integer model.
module tb_ovf_accumulator;

    localparam int W    = 8;
    localparam int CW   = 4;
    localparam int MAXI = 127;
    localparam int MINI = -128;
    localparam int CMAX = 15;

    logic          CLK;
    logic          RST;
    logic          EN;
    logic          CLR;
    logic          SUB;
    logic          SAT;
    logic [W-1:0]  D;
    logic [W-1:0]  ACC;
    logic          OVF;
    logic          STICKY;
    logic [CW-1:0] OVF_CNT;

    int checks;
    int errors;

    int acc_m;
    int ovf_m;
    int sticky_m;
    int cnt_m;

    ovf_accumulator #(
        .WIDTH(W),
        .CNT_WIDTH(CW)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .EN      (EN),
        .CLR     (CLR),
        .SUB     (SUB),
        .SAT     (SAT),
        .D       (D),
        .ACC     (ACC),
        .OVF     (OVF),
        .STICKY  (STICKY),
        .OVF_CNT (OVF_CNT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [W-1:0] ea;
        ea = W'(acc_m);
        chk({tag, ".acc"}, 32'(ACC), 32'(ea));
        chk({tag, ".ovf"}, 32'(OVF), 32'(ovf_m));
        chk({tag, ".sticky"}, 32'(STICKY), 32'(sticky_m));
        chk({tag, ".cnt"}, 32'(OVF_CNT), 32'(cnt_m));
    endtask

    // Reference: exact integer arithmetic, then range test against the
    // signed limits decides overflow and the committed value.
    task automatic model(input bit rst, input bit clr, input bit en,
                         input bit sub, input bit sat, input int d);
        int s;
        if (rst || clr) begin
            acc_m    = 0;
            ovf_m    = 0;
            sticky_m = 0;
            cnt_m    = 0;
        end else if (en) begin
            s     = sub ? acc_m - d : acc_m + d;
            ovf_m = 0;
            if (s > MAXI) begin
                ovf_m = 1;
                acc_m = sat ? MAXI : s - (1 << W);
            end else if (s < MINI) begin
                ovf_m = 1;
                acc_m = sat ? MINI : s + (1 << W);
            end else begin
                acc_m = s;
            end
            if (ovf_m == 1) begin
                sticky_m = 1;
                if (cnt_m < CMAX) cnt_m++;
            end
        end else begin
            ovf_m = 0;
        end
    endtask

    task automatic step(input string tag, input bit rst, input bit clr,
                        input bit en, input bit sub, input bit sat,
                        input int d);
        RST = rst;
        CLR = clr;
        EN  = en;
        SUB = sub;
        SAT = sat;
        D   = W'(d);
        @(posedge CLK);
        #1;
        model(rst, clr, en, sub, sat, d);
        check_model(tag);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        acc_m    = 0;
        ovf_m    = 0;
        sticky_m = 0;
        cnt_m    = 0;
        RST = 1'b1;
        CLR = 1'b0;
        EN  = 1'b1;
        SUB = 1'b0;
        SAT = 1'b0;
        D   = W'(5);

        // Reset held two cycles with a live operand
        step("rst0", 1, 0, 1, 0, 0, 5);
        step("rst1", 1, 0, 1, 0, 0, 5);
        chk("rst.acc", 32'(ACC), 32'(0));
        step("add5", 0, 0, 1, 0, 0, 5);
        chk("add5.acc", 32'(ACC), 32'(5));

        // Wrap
        step("clr", 0, 1, 0, 0, 0, 0);
        step("ld100", 0, 0, 1, 0, 0, 100);
        step("wrap", 0, 0, 1, 0, 0, 50);
        chk("wrap.acc", 32'(ACC), 32'h96);
        chk("wrap.ovf", 32'(OVF), 32'(1));
        step("idle", 0, 0, 0, 0, 0, 0);
        chk("idle.ovf", 32'(OVF), 32'(0));
        chk("idle.sticky", 32'(STICKY), 32'(1));

        // Saturate positive
        step("clr", 0, 1, 0, 0, 0, 0);
        step("ld100", 0, 0, 1, 0, 0, 100);
        step("satp", 0, 0, 1, 0, 1, 50);
        chk("satp.acc", 32'(ACC), 32'h7f);

        // Saturate / wrap negative via subtraction
        step("clr", 0, 1, 0, 0, 0, 0);
        step("ldm100", 0, 0, 1, 0, 0, -100);
        step("satn", 0, 0, 1, 1, 1, 100);
        chk("satn.acc", 32'(ACC), 32'h80);
        step("clr", 0, 1, 0, 0, 0, 0);
        step("ldm100", 0, 0, 1, 0, 0, -100);
        step("wrapn", 0, 0, 1, 1, 0, 100);
        chk("wrapn.acc", 32'(ACC), 32'(56));

        // Subtracting the most negative operand
        step("clr", 0, 1, 0, 0, 0, 0);
        step("submin.sat", 0, 0, 1, 1, 1, -128);
        chk("submin.sat.acc", 32'(ACC), 32'h7f);
        step("clr", 0, 1, 0, 0, 0, 0);
        step("submin.wrap", 0, 0, 1, 1, 0, -128);
        chk("submin.wrap.acc", 32'(ACC), 32'h80);
        step("clr", 0, 1, 0, 0, 0, 0);
        step("ldm1", 0, 0, 1, 0, 0, -1);
        step("submin.ok", 0, 0, 1, 1, 0, -128);
        chk("submin.ok.ovf", 32'(OVF), 32'(0));

        // CLR and EN together from a loaded state
        step("clr", 0, 1, 0, 0, 0, 0);
        step("ld100", 0, 0, 1, 0, 0, 100);
        for (int i = 0; i < 3; i++) step("satx", 0, 0, 1, 0, 1, 100);
        step("dn7", 0, 0, 1, 1, 0, 7);
        chk("pre.cnt", 32'(OVF_CNT), 32'(3));
        chk("pre.acc", 32'(ACC), 32'(120));
        step("clren", 0, 1, 1, 0, 0, 100);
        chk("clren.acc", 32'(ACC), 32'(0));

        // Counter saturation
        step("ld127", 0, 0, 1, 0, 0, 127);
        for (int i = 0; i < 17; i++) begin
            step("cntsat", 0, 0, 1, 0, 1, 127);
            chk("cntsat.ovf", 32'(OVF), 32'(1));
        end
        chk("cntsat.cnt", 32'(OVF_CNT), 32'(15));
        chk("cntsat.acc", 32'(ACC), 32'h7f);

        // Random operations
        step("clr", 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            bit r, c, e, s, t;
            int d;
            r = ($urandom_range(0, 99) < 2);
            c = ($urandom_range(0, 99) < 4);
            e = ($urandom_range(0, 99) < 80);
            s = 1'($urandom_range(0, 1));
            t = 1'($urandom_range(0, 1));
            d = int'($urandom_range(0, 255)) - 128;
            step("rand", r, c, e, s, t, d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ovf_accumulator.md
# ovf_accumulator

Parametrised signed accumulator with overflow detection, selectable wrap/saturate behaviour, a sticky overflow flag and a saturating overflow-event counter. It is the sequential successor to the 1-bit combinational adder overflow detector in the arithmetic components library. It sits behind any datapath that sums a signed stream and needs overflow reported rather than silently lost.

## Interface
- WIDTH, 8, accumulator and operand width in bits, two's complement, ≥2
- CNT_WIDTH, 4, overflow-event counter width, ≥1
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- EN  in  1  operand valid; D/SUB/SAT sampled when high
- CLR  in  1  synchronous clear of ACC, STICKY, OVF_CNT, OVF
- SUB  in  1  0: ACC + D, 1: ACC − D
- SAT  in  1  0: wrap on overflow, 1: clamp to signed limit
- D  in  WIDTH  signed operand
- ACC  out  WIDTH  registered accumulator value
- OVF  out  1  registered overflow pulse for the operation just committed
- STICKY  out  1  set on any overflow since last RST/CLR
- OVF_CNT  out  CNT_WIDTH  count of overflowing operations, saturates at all-ones

## Operation
- Only one clock and one synchronous, active-high reset; no asynchronous state.
- Arithmetic: sign-extend ACC and D to WIDTH+1 bits; form ext = ACC ± D. Overflow when ext[WIDTH] ≠ ext[WIDTH−1]. This covers SUB with D = −2^(WIDTH−1).
- Positive overflow: ext[WIDTH]=0. Negative overflow: ext[WIDTH]=1.
- Result when there is no overflow: ext[WIDTH−1:0].
- Result on overflow with SAT=0: ext[WIDTH−1:0] (wrap).
- Result on overflow with SAT=1: MAX = 2^(WIDTH−1)−1 for positive overflow, MIN = −2^(WIDTH−1) for negative overflow.
- Each EN cycle with an overflow:
  - OVF=1 next cycle.
  - STICKY set.
  - OVF_CNT increments unless already all-ones.
- Each EN cycle without an overflow: OVF=0 next cycle.
- Cycles with EN=0: ACC, STICKY and OVF_CNT hold; OVF=0.
- Priority is RST > CLR > EN.
  - CLR with EN in the same cycle: the operand is discarded, no overflow is counted, and all state clears.
- No state machine beyond the registers above. Mode signals are per-operation; changing SAT between operations has no retroactive effect.

## Timing
- Reset values: ACC=0, OVF=0, STICKY=0, OVF_CNT=0.
- Latency 1: operand sampled at edge k is reflected in ACC, OVF, STICKY and OVF_CNT after edge k. Full throughput, one operation per cycle.
- Back-to-back overflowing operations: OVF stays high for consecutive cycles and OVF_CNT increments every cycle until it saturates.
- The next operation uses the updated ACC, which is the clamped or wrapped value.
- RST or CLR asserted mid-stream: everything is zero after that edge. The operation presented in that cycle is lost.
- All outputs are driven directly from registers; there are no combinational paths from inputs to outputs.

## Structure
- Shared arithmetic package/header holds:
  - op encoding constants OP_ADD=0 and OP_SUB=1;
  - the signed MAX/MIN limit derivation, as a function of WIDTH, reused by other saturating blocks.
- Sub-module ovf_detect_n, combinational, parametrised WIDTH:
  - inputs: a, b, sub;
  - outputs: result, ovf, ovf_neg (the overflow direction).
  - It is the WIDTH-generic successor of the 1-bit overflow cell. It is instantiated once; registers, saturation mux and counter live in ovf_accumulator.
- Target is roughly 150–250 lines including the sub-module.

## Test plan
All cases use WIDTH=8, CNT_WIDTH=4.
- Reset: hold RST 2 cycles with EN=1, D=5 → ACC=0, OVF=0, STICKY=0, OVF_CNT=0. After release, one EN with D=5 → ACC=5 one cycle later.
- Wrap: from ACC=100, EN, SUB=0, SAT=0, D=50 → ACC=−106 (0x96), OVF=1 for one cycle, STICKY=1, OVF_CNT=1.
- Saturate:
  - from ACC=100, add 50 with SAT=1 → ACC=127, OVF=1.
  - from ACC=−100, SUB D=100 with SAT=1 → ACC=−128.
  - the same subtraction with SAT=0 → ACC=56.
- MIN operand: from ACC=0, SUB D=−128:
  - SAT=1 → ACC=127, OVF=1.
  - SAT=0 → ACC=−128, OVF=1.
  - from ACC=−1, SUB D=−128 → ACC=127, OVF=0.
- Simultaneous CLR and EN: from ACC=120, STICKY=1, OVF_CNT=3, apply CLR=1 with EN=1, D=100 → ACC=0, STICKY=0, OVF_CNT=0, OVF=0 next cycle.
- Counter saturation: 17 consecutive overflowing adds with SAT=1 and D=127 from ACC=127 → OVF high for 17 cycles, OVF_CNT stops at 15, STICKY=1, ACC=127 throughout.
